mandelbrot_engine: RTL
======================

// Module: mandelbrot_engine
// PURPOSE
//  Parametrised Mandelbrot renderer, next generation of the single-view engine. Walks a WIDTHxHEIGHT
//  frame in raster order and computes each pixel's escape count in signed fixed point.
//  Maps each count to RGB565, packs PIX_PER_WORD pixels per word and writes the words to the frame
//  buffer through the ram controller's do_write/ack handshake. The view window is a runtime
//  input: loading a new view aborts the current frame and restarts rendering.
// PARAMETERS
//  FW             64    fixed-point word width (signed, two's complement)
//  FRAC           24    fractional bits; the value 1.0 is (1<<FRAC)
//  MAX_ITER       500   iteration cap; a pixel that reaches it is treated as inside the set
//  WIDTH          1024  pixels per line
//  HEIGHT         768   lines per frame
//  PIX_PER_WORD   8     16-bit pixels per write word; WIDTH*HEIGHT must be a multiple of it
//  AW             28    write address width
// PORTS
//  clk            in   1        system clock
//  rst            in   1        asynchronous reset, active high
//  ram_init_done  in   1        frame buffer ready; no rendering starts while it is 0
//  is_writing     in   1        controller busy; the engine holds its state while it is 1
//  view_load      in   1        latch view_* and restart the frame
//  view_xb/yb     in   FW       real and imaginary value of c at pixel (0,0)
//  view_xs/ys     in   FW       per-pixel step in x and in y
//  view_ack       out  1        one-cycle pulse confirming the view was latched
//  do_write       out  1        write request; held high until ack
//  ack            in   1        controller accepted the word
//  where_write    out  AW       word address, in pixel units: 0, PPW, 2*PPW, ...
//  data_to_write  out  16*PPW   packed pixels; the first pixel of the word is in the MSBs
//  busy           out  1        frame in progress
//  frame_done     out  1        high from the last ack until the next view_load
// BEHAVIOUR
//  Reset: all outputs 0. View registers reset to xb=-2.0, yb=-1.0, xs=3/1024, ys=2/768.
//    With FRAC=24 these are -33554432, -16777216, 49152, 43690. Pixel, line, address and
//    pack counters reset to 0.
//  FSM: IDLE -> INIT -> ITER -> (EMIT) -> WRITE -> DONE.
//   IDLE: go to INIT once ram_init_done=1.
//   INIT (1 cycle): cx = xb + px*xs; cy = yb + py*ys. Set z = c and n = 0.
//   ITER: one iteration per clock. mul(a,b) = (a*b) >>> FRAC on a 2*FW-bit product,
//    truncated to FW bits. The escape test mul(x,x)+mul(y,y) >= 4<<FRAC is done at FW+2 bits
//    so it cannot overflow. If escaped or n==MAX_ITER, go to EMIT.
//    Otherwise x' = mul(x,x) - mul(y,y) + cx, y' = 2*mul(x,y) + cy, and n = n+1.
//   EMIT (1 cycle): if n==MAX_ITER the colour is 16'h0000, else palette[n[3:0]]. The palette
//    is the 16 fixed entries 445F, 47F8, FF08, 329F, A19B, CEC6, DC06, D6C6, 34F1, 79DB, 3ED3,
//    DCC7, 8EC7, 3B7B, AE6B, A2D9.
//    Shift the colour into the pack register at the LSB end. Advance px; on wrap px=0, advance py.
//    If the pack count reaches PPW, go to WRITE, otherwise go to INIT.
//   WRITE: do_write=1; where_write and data_to_write stay stable until ack=1 is sampled.
//    In that cycle do_write drops, the address advances by PPW and the pack count clears.
//    The next state is INIT, or DONE if this was the last word.
//   DONE: frame_done=1 and busy=0. Hold until view_load.
//  busy=1 in INIT, ITER, EMIT and WRITE.
//  is_writing=1 freezes INIT, ITER and EMIT. WRITE may still complete on ack.
//  view_load is accepted in any state and has priority over every other event.
//    Next cycle: view_ack=1, view registers updated, do_write=0, and the pending word is dropped
//    (any ack in that cycle is ignored). Pixel, line, address and pack counters clear,
//    frame_done clears, and the FSM goes to IDLE.
//  rst asserted mid-write drops do_write asynchronously and leaves no partial state.
//  An ack while do_write=0 is ignored.
// TESTING
//  Use WIDTH=8, HEIGHT=2, PPW=8, MAX_ITER=16 unless a scenario states otherwise.
//  T1 reset: every output 0. After reset release with ram_init_done=1, busy=1 within 2 cycles.
//  T2 escape colour: xb=2.0, xs=ys=0 -> every pixel escapes at n=0.
//    Two words, each 8 x 16'h445F, at addresses 0 then 8. Then frame_done=1.
//  T3 inside set: xb=yb=0, xs=ys=0 -> each pixel takes 16 iterations.
//    Data 128'h0, with 2 writes.
//  T4 ack stall: hold ack low for 20 cycles -> do_write, address and data stay stable and no pixel
//    advances. Ack for one cycle -> do_write falls the next cycle.
//  T5 abort: view_load while do_write=1 -> view_ack pulses and do_write drops. The next write goes
//    to address 0 with the new view's data.
//  T6 reset mid-ITER: assert rst -> counters cleared. After release the frame restarts at address 0.

Source files
------------

// File: rtl/mandelbrot_engine_if.sv
// ---------------------------------------------------------------------------
// mandelbrot_engine_if
//   Frame-buffer write channel between the Mandelbrot engine and the RAM
//   controller. The engine is the master and the controller is the slave.
//
//   ram_init_done  controller -> engine  frame buffer ready
//   is_writing     controller -> engine  controller busy, engine freezes compute
//   do_write       engine -> controller  write request, held until ack
//   ack            controller -> engine  word accepted
//   where_write    engine -> controller  word address in pixel units
//   data_to_write  engine -> controller  packed RGB565 pixels, first pixel in MSBs
// ---------------------------------------------------------------------------
interface mandelbrot_engine_if #(
    parameter int AW = 28,
    parameter int DW = 128
);
    logic          ram_init_done;
    logic          is_writing;
    logic          do_write;
    logic          ack;
    logic [AW-1:0] where_write;
    logic [DW-1:0] data_to_write;

    modport master (
        input  ram_init_done, is_writing, ack,
        output do_write, where_write, data_to_write
    );

    modport slave (
        output ram_init_done, is_writing, ack,
        input  do_write, where_write, data_to_write
    );
endinterface

// File: rtl/mandelbrot_engine.sv
// ---------------------------------------------------------------------------
// mandelbrot_engine
//   Walks a WIDTH x HEIGHT frame in raster order, iterates z = z^2 + c in
//   signed fixed point (FRAC fractional bits) for every pixel, maps the escape
//   count to RGB565, packs PIX_PER_WORD pixels per word and writes the words
//   to the frame buffer over the do_write/ack channel. Loading a new view
//   aborts the frame in progress and restarts rendering.
//
//   clk           system clock
//   rst           asynchronous reset, active high
//   wr            write channel (master modport of mandelbrot_engine_if)
//   view_load_i   latch view_*_i and restart the frame
//   view_xb_i/yb_i  c at pixel (0,0), real / imaginary
//   view_xs_i/ys_i  per-pixel step in x / y
//   view_ack_o    one-cycle pulse confirming the view was latched
//   busy_o        frame in progress
//   frame_done_o  high from the last ack until the next view load
// ---------------------------------------------------------------------------
module mandelbrot_engine #(
    parameter int FW           = 64,
    parameter int FRAC         = 24,
    parameter int MAX_ITER     = 500,
    parameter int WIDTH        = 1024,
    parameter int HEIGHT       = 768,
    parameter int PIX_PER_WORD = 8,
    parameter int AW           = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    mandelbrot_engine_if.master  wr,
    input  logic                 view_load_i,
    input  logic signed [FW-1:0] view_xb_i,
    input  logic signed [FW-1:0] view_yb_i,
    input  logic signed [FW-1:0] view_xs_i,
    input  logic signed [FW-1:0] view_ys_i,
    output logic                 view_ack_o,
    output logic                 busy_o,
    output logic                 frame_done_o
);

    localparam int DW = 16 * PIX_PER_WORD;
    localparam int PW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int LW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int NW = $clog2(MAX_ITER + 1);
    localparam int CW = $clog2(PIX_PER_WORD + 1);

    localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH * HEIGHT - PIX_PER_WORD);
    localparam logic [AW-1:0] ADDR_STEP = AW'(PIX_PER_WORD);
    localparam logic [NW-1:0] N_MAX     = NW'(MAX_ITER);
    localparam logic [CW-1:0] PACK_LAST = CW'(PIX_PER_WORD - 1);
    localparam logic [PW-1:0] PX_LAST   = PW'(WIDTH - 1);
    localparam logic [LW-1:0] PY_LAST   = LW'(HEIGHT - 1);

    // Default view: real [-2, 1), imaginary [-1, 1) over a 1024 x 768 frame.
    localparam logic signed [FW-1:0] ONE    = FW'(1) <<< FRAC;
    localparam logic signed [FW-1:0] XB_RST = -(ONE <<< 1);
    localparam logic signed [FW-1:0] YB_RST = -ONE;
    localparam logic signed [FW-1:0] XS_RST = (ONE * 3) / 1024;
    localparam logic signed [FW-1:0] YS_RST = (ONE * 2) / 768;
    localparam logic signed [FW+1:0] ESC_LIM = (FW+2)'(ONE) <<< 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ITER,
        S_EMIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic signed [FW-1:0]  xb_q, xb_d, yb_q, yb_d, xs_q, xs_d, ys_q, ys_d;
    logic signed [FW-1:0]  cx_q, cx_d, cy_q, cy_d, x_q, x_d, y_q, y_d;
    logic [NW-1:0]         n_q, n_d;
    logic [PW-1:0]         px_q, px_d;
    logic [LW-1:0]         py_q, py_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [CW-1:0]         pack_cnt_q, pack_cnt_d;
    logic [DW-1:0]         pack_q, pack_d;
    logic                  view_ack_q, view_ack_d;

    // Fixed-point multiply: full 2*FW-bit product, arithmetic shift by FRAC,
    // truncated back to FW bits. The low 2*FW bits of the product of the
    // sign-extended operands equal the signed product.
    function automatic logic signed [FW-1:0] mul(input logic signed [FW-1:0] a,
                                                 input logic signed [FW-1:0] b);
        logic signed [2*FW-1:0] p;
        p = {{FW{a[FW-1]}}, a} * {{FW{b[FW-1]}}, b};
        p = p >>> FRAC;
        return p[FW-1:0];
    endfunction

    function automatic logic [15:0] palette(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'h445F;
            4'd1:    return 16'h47F8;
            4'd2:    return 16'hFF08;
            4'd3:    return 16'h329F;
            4'd4:    return 16'hA19B;
            4'd5:    return 16'hCEC6;
            4'd6:    return 16'hDC06;
            4'd7:    return 16'hD6C6;
            4'd8:    return 16'h34F1;
            4'd9:    return 16'h79DB;
            4'd10:   return 16'h3ED3;
            4'd11:   return 16'hDCC7;
            4'd12:   return 16'h8EC7;
            4'd13:   return 16'h3B7B;
            4'd14:   return 16'hAE6B;
            default: return 16'hA2D9;
        endcase
    endfunction

    logic signed [FW-1:0] xx, yy, xy;
    logic signed [FW+1:0] mag;
    logic                 escaped;
    logic [15:0]          colour;

    always_comb begin
        xx      = mul(x_q, x_q);
        yy      = mul(y_q, y_q);
        xy      = mul(x_q, y_q);
        // Two guard bits keep the magnitude sum from wrapping.
        mag     = {{2{xx[FW-1]}}, xx} + {{2{yy[FW-1]}}, yy};
        escaped = (mag >= ESC_LIM);
        colour  = (n_q == N_MAX) ? 16'h0000 : palette(4'(n_q));
    end

    always_comb begin
        state_d    = state_q;
        xb_d       = xb_q;
        yb_d       = yb_q;
        xs_d       = xs_q;
        ys_d       = ys_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        x_d        = x_q;
        y_d        = y_q;
        n_d        = n_q;
        px_d       = px_q;
        py_d       = py_q;
        addr_d     = addr_q;
        pack_cnt_d = pack_cnt_q;
        pack_d     = pack_q;
        view_ack_d = 1'b0;

        if (view_load_i) begin
            // A view load overrides everything, including an ack for the
            // pending word, which is simply dropped.
            xb_d       = view_xb_i;
            yb_d       = view_yb_i;
            xs_d       = view_xs_i;
            ys_d       = view_ys_i;
            px_d       = '0;
            py_d       = '0;
            addr_d     = '0;
            pack_cnt_d = '0;
            pack_d     = '0;
            view_ack_d = 1'b1;
            state_d    = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wr.ram_init_done) state_d = S_INIT;
                end
                S_INIT: begin
                    if (!wr.is_writing) begin
                        cx_d    = xb_q + $signed(FW'(px_q)) * xs_q;
                        cy_d    = yb_q + $signed(FW'(py_q)) * ys_q;
                        x_d     = cx_d;
                        y_d     = cy_d;
                        n_d     = '0;
                        state_d = S_ITER;
                    end
                end
                S_ITER: begin
                    if (!wr.is_writing) begin
                        if (escaped || (n_q == N_MAX)) begin
                            state_d = S_EMIT;
                        end else begin
                            x_d = xx - yy + cx_q;
                            y_d = (xy <<< 1) + cy_q;
                            n_d = n_q + NW'(1);
                        end
                    end
                end
                S_EMIT: begin
                    if (!wr.is_writing) begin
                        pack_d     = (pack_q << 16) | DW'(colour);
                        pack_cnt_d = pack_cnt_q + CW'(1);
                        if (px_q == PX_LAST) begin
                            px_d = '0;
                            py_d = (py_q == PY_LAST) ? '0 : py_q + LW'(1);
                        end else begin
                            px_d = px_q + PW'(1);
                        end
                        state_d = (pack_cnt_q == PACK_LAST) ? S_WRITE : S_INIT;
                    end
                end
                S_WRITE: begin
                    if (wr.ack) begin
                        addr_d     = addr_q + ADDR_STEP;
                        pack_cnt_d = '0;
                        state_d    = (addr_q == LAST_ADDR) ? S_DONE : S_INIT;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            xb_q       <= XB_RST;
            yb_q       <= YB_RST;
            xs_q       <= XS_RST;
            ys_q       <= YS_RST;
            cx_q       <= '0;
            cy_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            n_q        <= '0;
            px_q       <= '0;
            py_q       <= '0;
            addr_q     <= '0;
            pack_cnt_q <= '0;
            pack_q     <= '0;
            view_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            xb_q       <= xb_d;
            yb_q       <= yb_d;
            xs_q       <= xs_d;
            ys_q       <= ys_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            x_q        <= x_d;
            y_q        <= y_d;
            n_q        <= n_d;
            px_q       <= px_d;
            py_q       <= py_d;
            addr_q     <= addr_d;
            pack_cnt_q <= pack_cnt_d;
            pack_q     <= pack_d;
            view_ack_q <= view_ack_d;
        end
    end

    // Outputs decode straight from registered state, so an asynchronous
    // reset drops do_write immediately.
    assign wr.do_write      = (state_q == S_WRITE);
    assign wr.where_write   = addr_q;
    assign wr.data_to_write = pack_q;
    assign view_ack_o       = view_ack_q;
    assign busy_o           = (state_q == S_INIT) || (state_q == S_ITER) ||
                              (state_q == S_EMIT) || (state_q == S_WRITE);
    assign frame_done_o     = (state_q == S_DONE);

endmodule
